// File: rtl/cv32e40p_hwloop_seq.sv
// Hardware-loop sequencer: detects retirement of a loop's last instruction, issues
// counter decrements to the loop registers and a registered loop-back redirect to fetch.
module cv32e40p_hwloop_seq #(
    parameter int N_REGS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc_i,
    input  logic                 instr_valid_i,
    input  logic [N_REGS*32-1:0] hwlp_start_i,
    input  logic [N_REGS*32-1:0] hwlp_end_i,
    input  logic [N_REGS*32-1:0] hwlp_cnt_i,
    input  logic [2:0]           hwlp_we_i,
    input  logic                 jump_ready_i,
    input  logic                 flush_i,
    output logic                 jump_req_o,
    output logic [31:0]          jump_target_o,
    output logic [N_REGS-1:0]    hwlp_dec_cnt_o,
    output logic                 valid_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        WSYNC,
        JUMP
    } state_e;

    state_e      state_q;
    logic        jump_req_q;
    logic [31:0] jump_target_q;
    logic        wr_pend_q;

    logic [N_REGS-1:0] loop_match;
    logic [N_REGS-1:0] scan_dec;
    logic              scan_hit;
    logic [31:0]       scan_target;
    logic              scan_go;
    logic              eval_en;
    logic              we_any;

    assign we_any  = |hwlp_we_i;
    assign eval_en = (state_q == IDLE) && instr_valid_i && !we_any && !flush_i && !rst;

    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            loop_match[k] = (hwlp_cnt_i[k*32 +: 32] != 32'd0) &&
                            (pc_i == hwlp_end_i[k*32 +: 32]);
        end
    end

    // Innermost-first scan: an exiting loop (count 1) lets the next outer loop be
    // considered; the first loop that still iterates supplies the target and ends the scan.
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        scan_dec    = '0;
        scan_hit    = 1'b0;
        scan_target = 32'h0;
        scan_go     = 1'b1;
        for (int k = 0; k < N_REGS; k++) begin
            if (scan_go && loop_match[k]) begin
                scan_dec[k] = 1'b1;
                if (hwlp_cnt_i[k*32 +: 32] != 32'd1) begin
                    scan_hit    = 1'b1;
                    scan_target = hwlp_start_i[k*32 +: 32];
                    scan_go     = 1'b0;
                end
            end
        end
    end

    assign hwlp_dec_cnt_o = eval_en ? scan_dec : '0;
    assign valid_o        = |hwlp_dec_cnt_o;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and update order inside the block does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            jump_req_q    <= 1'b0;
            jump_target_q <= 32'h0;
            wr_pend_q     <= 1'b0;
        end else if (flush_i) begin
            state_q    <= IDLE;
            jump_req_q <= 1'b0;
            wr_pend_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (we_any) begin
                        state_q <= WSYNC;
                    end else if (eval_en && scan_hit) begin
                        state_q       <= JUMP;
                        jump_req_q    <= 1'b1;
                        jump_target_q <= scan_target;
                    end
                end
                WSYNC: begin
                    if (!we_any) begin
                        state_q <= IDLE;
                    end
                end
                JUMP: begin
                    // A loop-register write during the redirect is remembered and
                    // synchronised once fetch has taken the jump.
                    if (jump_ready_i) begin
                        jump_req_q <= 1'b0;
                        wr_pend_q  <= 1'b0;
                        state_q    <= (wr_pend_q || we_any) ? WSYNC : IDLE;
                    end else if (we_any) begin
                        wr_pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    jump_req_q <= 1'b0;
                    wr_pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign jump_req_o    = jump_req_q;
    assign jump_target_o = jump_target_q;
    assign busy_o        = (state_q != IDLE);

endmodule
